// File: rtl/imm_packer_pkg.sv
// Shared definitions for the immediate packer: format codes,
// FSM states and RV32I immediate field masks.
package imm_packer_pkg;

   localparam logic [2:0] FMT_I = 3'b000;
   localparam logic [2:0] FMT_U = 3'b001;
   localparam logic [2:0] FMT_S = 3'b010;
   localparam logic [2:0] FMT_B = 3'b011;
   localparam logic [2:0] FMT_J = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   localparam logic [31:0] MASK_I = 32'hFFF0_0000;
   localparam logic [31:0] MASK_U = 32'hFFFF_F000;
   localparam logic [31:0] MASK_S = 32'hFE00_0F80;
   localparam logic [31:0] MASK_B = 32'hFE00_0F80;
   localparam logic [31:0] MASK_J = 32'hFFFF_F000;

   // True when v[31:lsb] is all ones or all zeros.
   function automatic logic uniform(
      input logic [31:0] v,
      input int          lsb
   );
      logic [31:0] m;
      m = 32'hFFFF_FFFF << lsb;
      return ((v & m) == m) || ((v & m) == 32'h0);
   endfunction

endpackage

// File: rtl/imm_pack_fn.sv
// Combinational immediate scatter and range check for one
// instruction template; inverse of the immediate extender.
module imm_pack_fn
   import imm_packer_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] tmpl,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = tmpl;
      legal = 1'b0;
      unique case (1'b1)
         (fmt == FMT_I): begin
            word  = (tmpl & ~MASK_I)
                  | {imm[11:0], 20'b0};
            legal = uniform(imm, 11);
         end
         (fmt == FMT_U): begin
            word  = (tmpl & ~MASK_U)
                  | {imm[31:12], 12'b0};
            legal = (imm[11:0] == 12'h0);
         end
         (fmt == FMT_S): begin
            word  = (tmpl & ~MASK_S)
                  | {imm[11:5], 13'b0,
                     imm[4:0], 7'b0};
            legal = uniform(imm, 11);
         end
         (fmt == FMT_B): begin
            word  = (tmpl & ~MASK_B)
                  | {imm[12], imm[10:5], 13'b0,
                     imm[4:1], imm[11], 7'b0};
            legal = uniform(imm, 12) & ~imm[0];
         end
         (fmt == FMT_J): begin
            word  = (tmpl & ~MASK_J)
                  | {imm[20], imm[10:1], imm[11],
                     imm[19:12], 12'b0};
            legal = uniform(imm, 20) & ~imm[0];
         end
         default: begin
            word  = tmpl;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// Packs immediates into instruction templates and streams the
// words into instruction memory at auto-incrementing addresses.
module imm_packer
   import imm_packer_pkg::*;
#(
   parameter int AW    = 10,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_fmt,
   input  logic [31:0]   in_tmpl,
   input  logic [31:0]   in_imm,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   input  logic          im_ready,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [7:0]    err_cnt,
   output logic [AW:0]   words
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   state_t        state;
   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW:0]   cnt;
   logic [AW-1:0] addr;

   logic [31:0]   pk_word;
   logic          pk_legal;
   logic          acc;
   logic          push;
   logic          pop;
   logic          rej;

   imm_pack_fn u_pack (
      .fmt   (in_fmt),
      .tmpl  (in_tmpl),
      .imm   (in_imm),
      .word  (pk_word),
      .legal (pk_legal)
   );

   assign in_ready = (state == ST_RUN) && (cnt != CNT_FULL);
   assign acc      = in_valid & in_ready;
   assign push     = acc & pk_legal;
   assign rej      = acc & ~pk_legal;
   assign pop      = im_we & im_ready;

   assign im_we    = (cnt != '0);
   assign im_addr  = addr;
   assign im_wdata = mem[rp];
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DRAIN) && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         addr    <= '0;
         err     <= 1'b0;
         err_cnt <= '0;
         words   <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= pk_word;
            wp      <= wp + 1'b1;
         end
         if (pop) begin
            rp   <= rp + 1'b1;
            addr <= addr + 1'b1;
            if (words != '1)
               words <= words + 1'b1;
         end
         cnt <= cnt + {{PW{1'b0}}, push}
                    - {{PW{1'b0}}, pop};
         if (rej) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 1'b1;
         end
         // No traffic in IDLE, so session setup needs no merging
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_RUN;
                  addr    <= base_addr;
                  err     <= 1'b0;
                  err_cnt <= '0;
                  words   <= '0;
               end
            end
            ST_RUN: begin
               if (flush)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (cnt == '0)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: directed packing vectors,
// extender round trip, backpressure, wrap, drain and reset.
module tb_imm_packer;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_fmt = '0;
   logic [31:0]   in_tmpl = '0;
   logic [31:0]   in_imm = '0;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic          im_ready = 1'b0;
   logic          busy;
   logic          done;
   logic          err;
   logic [7:0]    err_cnt;
   logic [AW:0]   words;

   imm_packer #(.AW(AW), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_tmpl   (in_tmpl),
      .in_imm    (in_imm),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .im_ready  (im_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_cnt   (err_cnt),
      .words     (words)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      bit            rt;
      logic [2:0]    fmt;
      logic [31:0]   imm;
   } exp_t;

   exp_t          sbq[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [AW-1:0] nxt = '0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Independent immediate extender used for the round trip
   function automatic logic [31:0] ext(input logic [31:0] w,
                                       input logic [2:0]  f);
      case (f)
         3'b000: ext = {{20{w[31]}}, w[31:20]};
         3'b001: ext = {w[31:12], 12'b0};
         3'b010: ext = {{20{w[31]}}, w[31:25], w[11:7]};
         3'b011: ext = {{19{w[31]}}, w[31], w[7],
                        w[30:25], w[11:8], 1'b0};
         3'b100: ext = {{11{w[31]}}, w[31], w[19:12],
                        w[20], w[30:21], 1'b0};
         default: ext = 32'hDEAD_BEEF;
      endcase
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && im_we && im_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_extra: got %h@%h want none",
                        im_wdata, im_addr);
            end else begin
               e = sbq.pop_front();
               chk("wr_addr", 32'(im_addr), 32'(e.addr));
               if (e.rt) begin
                  chk("rt_imm", ext(im_wdata, e.fmt), e.imm);
                  chk("rt_opc", 32'(im_wdata[6:0]), 32'h13);
               end else begin
                  chk("wr_data", im_wdata, e.data);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [2:0]  f,
                       input logic [31:0] t,
                       input logic [31:0] i,
                       input bit          lg,
                       input bit          rt,
                       input logic [31:0] d);
      bit   ok;
      int   b;
      exp_t e;
      ok = 1'b0;
      b  = 0;
      in_valid = 1'b1;
      in_fmt   = f;
      in_tmpl  = t;
      in_imm   = i;
      while (!ok && b < 40) begin
         @(negedge clk);
         ok = in_ready;
         if (ok && lg) begin
            e.addr = nxt;
            e.data = d;
            e.rt   = rt;
            e.fmt  = f;
            e.imm  = i;
            sbq.push_back(e);
            nxt++;
         end
         @(posedge clk);
         #1;
         b++;
      end
      in_valid = 1'b0;
      if (!ok)
         chk("send_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_start(input logic [AW-1:0] b);
      base_addr = b;
      start     = 1'b1;
      step(1);
      start     = 1'b0;
      nxt       = b;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
   endtask

   task automatic wait_done(input int exp_words);
      bit seen;
      seen = 1'b0;
      for (int b = 0; b < 100; b++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_words", 32'(words), 32'(exp_words));
      chk("done_sb_empty", 32'(sbq.size()), 32'd0);
      chk("done_im_we", 32'(im_we), 32'd0);
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, "_im_we"}, 32'(im_we), 32'd0);
      chk({nm, "_im_addr"}, 32'(im_addr), 32'd0);
      chk({nm, "_im_wdata"}, im_wdata, 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_done"}, 32'(done), 32'd0);
      chk({nm, "_err"}, 32'(err), 32'd0);
      chk({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
      chk({nm, "_words"}, 32'(words), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk_zero("rst");
      step(2);
      rst_n = 1'b1;
      step(1);

      // Round trip plus directed vectors
      im_ready = 1'b1;
      do_start(10'h010);
      send(3'b000, 32'h13, 32'd5, 1, 1, 0);
      send(3'b000, 32'h13, 32'hFFFF_F800, 1, 1, 0);
      send(3'b000, 32'h13, 32'd2047, 1, 1, 0);
      send(3'b001, 32'h13, 32'hABCD_E000, 1, 1, 0);
      send(3'b010, 32'h13, 32'hFFFF_FFFF, 1, 1, 0);
      send(3'b010, 32'h13, 32'd100, 1, 1, 0);
      send(3'b011, 32'h13, 32'd4094, 1, 1, 0);
      send(3'b011, 32'h13, 32'hFFFF_F000, 1, 1, 0);
      send(3'b100, 32'h13, 32'h000F_FFFE, 1, 1, 0);
      send(3'b100, 32'h13, 32'hFFF0_0000, 1, 1, 0);
      send(3'b000, 32'h13, 32'hFFFF_FFFF, 1, 0, 32'hFFF0_0013);
      send(3'b001, 32'h37, 32'h1234_5000, 1, 0, 32'h1234_5037);
      send(3'b011, 32'h63, 32'hFFFF_FFFC, 1, 0, 32'hFE00_0EE3);
      send(3'b100, 32'h6F, 32'd8, 1, 0, 32'h0080_006F);
      for (int b = 0; b < 20 && sbq.size() != 0; b++)
         step(1);
      step(2);
      chk("pre_ill_words", 32'(words), 32'd14);
      chk("pre_ill_err", 32'(err), 32'd0);

      send(3'b000, 32'h13, 32'd2048, 0, 0, 0);
      send(3'b011, 32'h63, 32'd3, 0, 0, 0);
      send(3'b001, 32'h37, 32'd1, 0, 0, 0);
      send(3'b101, 32'h13, 32'd0, 0, 0, 0);
      step(3);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_err_cnt", 32'(err_cnt), 32'd4);
      chk("ill_words", 32'(words), 32'd14);
      chk("ill_im_we", 32'(im_we), 32'd0);
      do_flush();
      wait_done(14);

      // Backpressure with three pending requests
      do_start(10'h200);
      chk("start_err_clr", 32'(err), 32'd0);
      chk("start_cnt_clr", 32'(err_cnt), 32'd0);
      im_ready = 1'b0;
      fork
         begin
            send(3'b000, 32'h13, 32'd1, 1, 0, 32'h0010_0013);
            send(3'b001, 32'h37, 32'h1000, 1, 0, 32'h0000_1037);
            send(3'b010, 32'h23, 32'd8, 1, 0, 32'h0000_0423);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_im_we", 32'(im_we), 32'd1);
            chk("bp_addr0", 32'(im_addr), 32'h200);
            chk("bp_data0", im_wdata, 32'h0010_0013);
            repeat (2) @(negedge clk);
            chk("bp_addr1", 32'(im_addr), 32'h200);
            chk("bp_data1", im_wdata, 32'h0010_0013);
            chk("bp_words", 32'(words), 32'd0);
            @(posedge clk);
            #1;
            im_ready = 1'b1;
         end
      join
      do_flush();
      wait_done(3);

      // Address wrap and drain under flush
      do_start(10'h3FE);
      im_ready = 1'b1;
      send(3'b000, 32'h13, 32'd1, 1, 0, 32'h0010_0013);
      send(3'b000, 32'h13, 32'd2, 1, 0, 32'h0020_0013);
      send(3'b000, 32'h13, 32'd3, 1, 0, 32'h0030_0013);
      send(3'b000, 32'h13, 32'd4, 1, 0, 32'h0040_0013);
      im_ready = 1'b0;
      do_flush();
      step(3);
      chk("drain_done", 32'(done), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_im_we", 32'(im_we), 32'd1);
      im_ready = 1'b1;
      wait_done(4);
      chk("wrap_addr", 32'(im_addr), 32'h002);

      // Reset mid-session with a full buffer
      do_start(10'h050);
      im_ready = 1'b0;
      send(3'b000, 32'h13, 32'd7, 0, 0, 0);
      send(3'b000, 32'h13, 32'd9, 0, 0, 0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      step(2);
      rst_n = 1'b1;
      step(1);
      im_ready = 1'b1;
      do_start(10'h060);
      send(3'b100, 32'h6F, 32'd8, 1, 0, 32'h0080_006F);
      do_flush();
      wait_done(1);
      chk("final_addr", 32'(im_addr), 32'h061);

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_packer.md
# imm_packer

Inverse of the pipeline's immediate extender: accepts an instruction template plus a 32-bit signed/unsigned immediate and a format code, range-checks the immediate, scatters its bits into the RV32I I/U/S/B/J field positions, and streams the finished words into instruction memory through an auto-incrementing write port. It sits between the program loader and the instruction memory's write side, and is used both for boot-time program loading and for round-trip verification of the extender.

## Interface
- AW, 10, instruction-memory word-address width
- DEPTH, 2, output buffer entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a load session
- base_addr  in  AW  first word address of the session, sampled on start
- flush  in  1  one-cycle pulse, ends the session after draining
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_fmt  in  3  format: 000 I, 001 U, 010 S, 011 B, 100 J, 101–111 reserved
- in_tmpl  in  32  instruction template (opcode/funct/rd/rs fields)
- in_imm  in  32  immediate value (byte offset for B/J)
- im_we  out  1  memory write request
- im_addr  out  AW  memory word address
- im_wdata  out  32  packed instruction
- im_ready  in  1  memory accepts write when im_we & im_ready
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky, set on any rejected request, cleared by start
- err_cnt  out  8  rejected-request count, saturating at 255, cleared by start
- words  out  AW+1  words written this session, cleared by start

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: start → RUN; load addr←base_addr, clear err, err_cnt, words. flush ignored.
- RUN: in_ready = buffer not full. flush → DRAIN. start ignored.
- DRAIN: in_ready=0; when buffer empty → IDLE with done pulse the same cycle as the transition.
- Packing (template bits in immediate field positions are cleared, then immediate OR'd in):
  - I: [31:20]←imm[11:0]; legal iff imm[31:11] all equal.
  - U: [31:12]←imm[31:12]; legal iff imm[11:0]==0.
  - S: [31:25]←imm[11:5], [11:7]←imm[4:0]; legal as I.
  - B: [31]←imm[12], [7]←imm[11], [30:25]←imm[10:5], [11:8]←imm[4:1]; legal iff imm[31:12] all equal and imm[0]==0.
  - J: [31]←imm[20], [19:12]←imm[19:12], [20]←imm[11], [30:21]←imm[10:1]; legal iff imm[31:20] all equal and imm[0]==0.
  - Reserved fmt: always illegal.
- Illegal request: still handshaken (in_ready obeyed), not buffered; err←1, err_cnt+1 (saturating).
- Legal request: packed word pushed into DEPTH-entry FIFO.
- im_we = FIFO non-empty (RUN or DRAIN); im_wdata = FIFO head; im_addr = addr.
- On im_we & im_ready: pop, addr+1 (wraps modulo 2^AW), words+1 (saturates at 2^(AW+1)-1).
- Simultaneous push and pop on full FIFO: not permitted (in_ready=0 when full; no bypass).
- Reset (any time, including mid-session): state IDLE, FIFO empty, addr=0, all outputs 0; in-flight words discarded.

## Timing
- Reset values: in_ready 0, im_we 0, im_addr 0, im_wdata 0, busy 0, done 0, err 0, err_cnt 0, words 0.
- Packing and legality are combinational on the input; the FIFO registers the result.
- Latency: legal request accepted at edge N → im_we high after edge N (visible cycle N+1) if FIFO was empty.
- Throughput: one word per cycle sustained while im_ready=1.
- im_we/im_addr/im_wdata hold stable while im_we & !im_ready.
- in_ready registered-free but depends only on state and FIFO count, not on in_valid.
- flush and start in the same cycle: in IDLE start wins; in RUN flush wins.

## Structure
- Shared package: format codes (FMT_I…FMT_J, matching the extender's select encoding), FSM state enum, field bit-position constants.
- One sub-module natural: imm_pack_fn (combinational pack + legality check), reused by the bench as a reference model against the extender.
- FIFO inline (pointers + count); no separate module.

## Test plan
- Round trip: session at base 0x010; for each format feed random legal imms with tmpl=0x00000013 → im_wdata through the extender returns in_imm exactly; im_addr 0x010,0x011,…
- Vectors: I imm=-1, tmpl 0x00000013 → 0xFFF00013; U imm=0x12345000, tmpl 0x37 → 0x12345037; B imm=-4, tmpl 0x00000063 → 0xFE000EE3; J imm=8, tmpl 0x0000006F → 0x0080006F.
- Illegal: I imm=2048, B imm=3, U imm=0x1, fmt=101 → no writes, err=1, err_cnt=4, words unchanged.
- Backpressure: im_ready=0 for 5 cycles with 3 pending requests → in_ready drops after 2 accepted, outputs stable, all words land in order once released.
- Wrap and drain: AW=10, base 0x3FE, 4 words → addresses 0x3FE,0x3FF,0x000,0x001; flush mid-stream → done pulses only after last write, busy low next cycle.
- Reset mid-session with FIFO full → all outputs zero immediately, new start works normally.
